// File: rtl/mips_pkg.sv
// Shared constants for the MIPS writeback/register-file slice.
// Register 0 is architecturally hard-wired to zero.
package mips_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;
    localparam logic [ADDR_W-1:0] REG_ZERO = {ADDR_W{1'b0}};
endpackage

// File: rtl/wb_regfile_load_scoreboard.sv
// Per-register load-pending scoreboard and load-use hazard detection.
// A load writing back this cycle is not a hazard because the regfile bypass supplies the data.
module load_scoreboard
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic              issue_is_load,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic              wb_reg_write,
    input  logic              wb_mem_to_reg,
    input  logic [ADDR_W-1:0] wb_write_reg,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              load_stall
);
    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_pending_next;
    logic             w_set;
    logic             w_clr;
    logic             w_haz_a;
    logic             w_haz_b;

    assign w_set = issue_valid && issue_is_load && (issue_dest != REG_ZERO);
    assign w_clr = wb_reg_write && wb_mem_to_reg && (wb_write_reg != REG_ZERO);

    // Next pending vector; the set is applied after the clear so a new load wins.
    always_comb begin
        w_pending_next = r_pending;
        if (w_clr) begin
            w_pending_next[wb_write_reg] = 1'b0;
        end else begin
            w_pending_next = w_pending_next;
        end
        if (w_set) begin
            w_pending_next[issue_dest] = 1'b1;
        end else begin
            w_pending_next = w_pending_next;
        end
        w_pending_next[0] = 1'b0;
    end

    // Pending-bit register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= {NREGS{1'b0}};
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // Hazard compare on both read ports.
    always_comb begin
        w_haz_a = 1'b0;
        w_haz_b = 1'b0;
        if ((rs_addr != REG_ZERO) && r_pending[rs_addr] &&
            !(w_clr && (wb_write_reg == rs_addr))) begin
            w_haz_a = 1'b1;
        end else begin
            w_haz_a = 1'b0;
        end
        if ((rt_addr != REG_ZERO) && r_pending[rt_addr] &&
            !(w_clr && (wb_write_reg == rt_addr))) begin
            w_haz_b = 1'b1;
        end else begin
            w_haz_b = 1'b0;
        end
    end

    assign load_stall = w_haz_a | w_haz_b;
endmodule

// File: rtl/wb_regfile.sv
// Writeback select, 32-entry register file with write-through read bypass,
// and the load-use scoreboard feeding the hazard/PC logic.
module wb_regfile
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] wb_mem_data,
    input  logic [DATA_W-1:0] wb_alu_data,
    input  logic [ADDR_W-1:0] wb_write_reg,
    input  logic              wb_reg_write,
    input  logic              wb_mem_to_reg,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    input  logic              issue_valid,
    input  logic              issue_is_load,
    input  logic [ADDR_W-1:0] issue_dest,
    output logic              load_stall
);
    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] w_wb_data;

    assign w_wb_data = wb_mem_to_reg ? wb_mem_data : wb_alu_data;
    assign wb_data   = w_wb_data;

    // Register array commit; entry 0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
        end else if (wb_reg_write && (wb_write_reg != REG_ZERO)) begin
            r_regs[wb_write_reg] <= w_wb_data;
        end else begin
            r_regs <= r_regs;
        end
    end

    // Read ports: zero register, then same-cycle writeback bypass, then array.
    always_comb begin
        rs_data = {DATA_W{1'b0}};
        rt_data = {DATA_W{1'b0}};
        if (rs_addr == REG_ZERO) begin
            rs_data = {DATA_W{1'b0}};
        end else if (wb_reg_write && (wb_write_reg == rs_addr)) begin
            rs_data = w_wb_data;
        end else begin
            rs_data = r_regs[rs_addr];
        end
        if (rt_addr == REG_ZERO) begin
            rt_data = {DATA_W{1'b0}};
        end else if (wb_reg_write && (wb_write_reg == rt_addr)) begin
            rt_data = w_wb_data;
        end else begin
            rt_data = r_regs[rt_addr];
        end
    end

    load_scoreboard u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_is_load (issue_is_load),
        .issue_dest    (issue_dest),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_write_reg  (wb_write_reg),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .load_stall    (load_stall)
    );
endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: bypass, r0, writeback select,
// and the load scoreboard lifecycle including same-edge set/clear and reset.
module tb_wb_regfile;
    logic        clk;
    logic        reset;
    logic [31:0] wb_mem_data;
    logic [31:0] wb_alu_data;
    logic [4:0]  wb_write_reg;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data;
    logic        issue_valid;
    logic        issue_is_load;
    logic [4:0]  issue_dest;
    logic        load_stall;

    int n_checks;
    int n_fail;

    wb_regfile dut (
        .clk           (clk),
        .reset         (reset),
        .wb_mem_data   (wb_mem_data),
        .wb_alu_data   (wb_alu_data),
        .wb_write_reg  (wb_write_reg),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .wb_data       (wb_data),
        .issue_valid   (issue_valid),
        .issue_is_load (issue_is_load),
        .issue_dest    (issue_dest),
        .load_stall    (load_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle inputs just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wb();
        wb_reg_write  = 1'b0;
        wb_mem_to_reg = 1'b0;
        wb_write_reg  = 5'd0;
        issue_valid   = 1'b0;
        issue_is_load = 1'b0;
        issue_dest    = 5'd0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        wb_mem_data = 32'd0;
        wb_alu_data = 32'd0;
        rs_addr     = 5'd0;
        rt_addr     = 5'd0;
        idle_wb();
        step();
        step();
        reset = 1'b0;

        // Reset then read
        rs_addr = 5'd5;
        rt_addr = 5'd31;
        #1;
        check("rst_rs", rs_data, 32'd0);
        check("rst_rt", rt_data, 32'd0);
        check("rst_stall", {31'd0, load_stall}, 32'd0);

        // ALU writeback with bypass
        wb_alu_data   = 32'h1234_5678;
        wb_mem_data   = 32'h5555_AAAA;
        wb_write_reg  = 5'd8;
        wb_reg_write  = 1'b1;
        wb_mem_to_reg = 1'b0;
        rs_addr       = 5'd8;
        #1;
        check("alu_wbdata", wb_data, 32'h1234_5678);
        check("alu_bypass", rs_data, 32'h1234_5678);
        step();
        idle_wb();
        #1;
        check("alu_stored", rs_data, 32'h1234_5678);

        // Memory-select writeback
        wb_mem_data   = 32'hDEAD_BEEF;
        wb_alu_data   = 32'h0BAD_F00D;
        wb_mem_to_reg = 1'b1;
        wb_write_reg  = 5'd9;
        wb_reg_write  = 1'b1;
        #1;
        check("mem_wbdata", wb_data, 32'hDEAD_BEEF);
        step();
        idle_wb();
        rt_addr = 5'd9;
        #1;
        check("mem_stored", rt_data, 32'hDEAD_BEEF);
        check("r8_kept", rs_data, 32'h1234_5678);

        // r0 protection
        wb_alu_data   = 32'hFFFF_FFFF;
        wb_mem_to_reg = 1'b0;
        wb_write_reg  = 5'd0;
        wb_reg_write  = 1'b1;
        rs_addr       = 5'd0;
        rt_addr       = 5'd8;
        #1;
        check("r0_bypass", rs_data, 32'd0);
        step();
        idle_wb();
        #1;
        check("r0_after", rs_data, 32'd0);
        check("r0_r8_kept", rt_data, 32'h1234_5678);

        // Load-use stall lifecycle on r10
        rs_addr       = 5'd0;
        rt_addr       = 5'd0;
        issue_valid   = 1'b1;
        issue_is_load = 1'b1;
        issue_dest    = 5'd10;
        #1;
        check("ld_issue_nostall", {31'd0, load_stall}, 32'd0);
        step();
        idle_wb();
        rs_addr = 5'd10;
        #1;
        check("ld_stall_rs", {31'd0, load_stall}, 32'd1);
        rs_addr = 5'd0;
        rt_addr = 5'd10;
        #1;
        check("ld_stall_rt", {31'd0, load_stall}, 32'd1);
        step();
        rt_addr       = 5'd0;
        rs_addr       = 5'd10;
        wb_mem_data   = 32'hCAFE_0010;
        wb_alu_data   = 32'h0000_0001;
        wb_mem_to_reg = 1'b1;
        wb_write_reg  = 5'd10;
        wb_reg_write  = 1'b1;
        #1;
        check("ld_wb_nostall", {31'd0, load_stall}, 32'd0);
        check("ld_wb_bypass", rs_data, 32'hCAFE_0010);
        step();
        idle_wb();
        #1;
        check("ld_cleared", {31'd0, load_stall}, 32'd0);
        check("ld_stored", rs_data, 32'hCAFE_0010);

        // Non-load writeback to a pending register leaves the bit set
        rs_addr       = 5'd0;
        issue_valid   = 1'b1;
        issue_is_load = 1'b1;
        issue_dest    = 5'd11;
        step();
        idle_wb();
        wb_alu_data   = 32'h0000_0011;
        wb_mem_to_reg = 1'b0;
        wb_write_reg  = 5'd11;
        wb_reg_write  = 1'b1;
        rs_addr       = 5'd11;
        #1;
        check("alu_noclr_same", {31'd0, load_stall}, 32'd1);
        step();
        idle_wb();
        #1;
        check("alu_noclr_next", {31'd0, load_stall}, 32'd1);

        // Same-edge set and clear of r3, with r3 already pending
        rs_addr       = 5'd0;
        issue_valid   = 1'b1;
        issue_is_load = 1'b1;
        issue_dest    = 5'd3;
        step();
        wb_mem_data   = 32'h0000_0333;
        wb_mem_to_reg = 1'b1;
        wb_write_reg  = 5'd3;
        wb_reg_write  = 1'b1;
        step();
        idle_wb();
        rs_addr = 5'd3;
        #1;
        check("setwins_stall", {31'd0, load_stall}, 32'd1);

        // Reset discards pending loads and clears the array
        reset = 1'b1;
        step();
        reset   = 1'b0;
        rs_addr = 5'd3;
        rt_addr = 5'd11;
        #1;
        check("rst_pend_stall", {31'd0, load_stall}, 32'd0);
        rs_addr = 5'd8;
        rt_addr = 5'd9;
        #1;
        check("rst_r8", rs_data, 32'd0);
        check("rst_r9", rt_data, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
